rf_alu_pipe: RTL

Parametrised successor to the combinational register-file-plus-ALU datapath: a 2^ADDR x SIZE register file feeding a one-stage registered ALU with a valid/ready issue handshake.
- Result writeback to the register file, with operand and flag forwarding.
- Architectural NZCV flag register with carry-in ops.
- Output backpressure.
Sits between the future instruction-decode stage and the memory/writeback logic of the multi-cycle CPU.

---
 rtl/rf_alu_pipe.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/rf_alu_pipe.sv
// rf_alu_pipe: a 2^ADDR x SIZE register file feeding a one-stage registered
// ALU with a valid/ready issue handshake and a hold stage with backpressure.
//
// Ports
//   Clk                 clock, all state changes on the rising edge
//   Clr                 synchronous active-high reset, highest priority
//   In_Valid/In_Ready   issue handshake; accept = In_Valid & In_Ready
//   OP                  ALU opcode (see localparams below)
//   R_Addr_A/R_Addr_B   operand register addresses
//   W_Addr, Write_Reg   destination register and write enable on retire
//   Write_Select        1 = pass Input_Data instead of the ALU result
//   Set_Flags           update the NZCV register on retire
//   Input_Data          external write data
//   R_Addr_C/R_Data_C   debug read of the architectural file (no forwarding)
//   Out_Valid/Out_Ready hold-stage handshake; retire = Out_Valid & Out_Ready
//   F, N, Z, C, V       held result and the flags it produced
//   Flag_N..Flag_V      architectural flag register
module rf_alu_pipe #(
  parameter int ADDR    = 4,
  parameter int SIZE    = 32,
  parameter int ZERO_R0 = 0
) (
  input  logic            Clk,
  input  logic            Clr,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [3:0]      OP,
  input  logic [ADDR-1:0] R_Addr_A,
  input  logic [ADDR-1:0] R_Addr_B,
  input  logic [ADDR-1:0] W_Addr,
  input  logic            Write_Reg,
  input  logic            Write_Select,
  input  logic            Set_Flags,
  input  logic [SIZE-1:0] Input_Data,
  input  logic [ADDR-1:0] R_Addr_C,
  output logic [SIZE-1:0] R_Data_C,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [SIZE-1:0] F,
  output logic            N,
  output logic            Z,
  output logic            C,
  output logic            V,
  output logic            Flag_N,
  output logic            Flag_Z,
  output logic            Flag_C,
  output logic            Flag_V
);

  localparam int SHW   = $clog2(SIZE);
  localparam int DEPTH = 2 ** ADDR;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBC  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_SLT  = 4'd11;
  localparam logic [3:0] OP_SLTU = 4'd12;
  localparam logic [3:0] OP_MOVB = 4'd13;

  // Register 0 is hardwired to zero only when ZERO_R0 is set.
  function automatic logic is_zero_reg(input logic [ADDR-1:0] ad);
    return (ZERO_R0 != 0) && (ad == '0);
  endfunction

  logic [SIZE-1:0] rf_q [DEPTH];
  logic            flag_n_q, flag_z_q, flag_c_q, flag_v_q;

  // Hold-stage registers
  logic            vld_p1;
  logic [SIZE-1:0] f_p1;
  logic            n_p1, z_p1, c_p1, v_p1;
  logic [ADDR-1:0] waddr_p1;
  logic            wreg_p1;
  logic            setf_p1;

  logic            accept, retire;
  logic            fwd_a, fwd_b;
  logic [SIZE-1:0] a, b, bx;
  logic            cin, cin_fwd;
  logic [SIZE:0]   sum;
  logic [SIZE:0]   sll_t, srl_t;
  logic signed [SIZE:0] sra_t;
  logic [SHW-1:0]  amt;
  logic signed [SIZE-1:0] a_s, b_s;
  logic [SIZE-1:0] alu_f, f_d;
  logic            alu_c, alu_v;

  assign In_Ready = !vld_p1 || Out_Ready;
  assign accept   = In_Valid && In_Ready;
  assign retire   = vld_p1 && Out_Ready;

  assign R_Data_C = is_zero_reg(R_Addr_C) ? '0 : rf_q[R_Addr_C];

  // Issue stage: operand read with forwarding from the held write value
  assign fwd_a = vld_p1 && wreg_p1 && (waddr_p1 == R_Addr_A) && !is_zero_reg(R_Addr_A);
  assign fwd_b = vld_p1 && wreg_p1 && (waddr_p1 == R_Addr_B) && !is_zero_reg(R_Addr_B);

  always_comb begin
    a = rf_q[R_Addr_A];
    if (is_zero_reg(R_Addr_A))  a = '0;
    else if (fwd_a)             a = f_p1;
    b = rf_q[R_Addr_B];
    if (is_zero_reg(R_Addr_B))  b = '0;
    else if (fwd_b)             b = f_p1;
  end

  // The held op's carry is the architectural carry-to-be if it sets flags.
  assign cin_fwd = (vld_p1 && setf_p1) ? c_p1 : flag_c_q;
  assign amt     = b[SHW-1:0];
  assign a_s     = a;
  assign b_s     = b;

  always_comb begin
    bx  = b;
    cin = 1'b0;
    case (OP)
      OP_ADC: cin = cin_fwd;
      OP_SUB: begin bx = ~b; cin = 1'b1;    end
      OP_SBC: begin bx = ~b; cin = cin_fwd; end
      default: ;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, bx} + {{SIZE{1'b0}}, cin};

  // Extra guard bit on each shift captures the last bit shifted out;
  // it is naturally 0 for a zero shift amount.
  assign sll_t = {1'b0, a} << amt;
  assign srl_t = {a, 1'b0} >> amt;
  assign sra_t = $signed({a, 1'b0}) >>> amt;

  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (OP)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        alu_f = sum[SIZE-1:0];
        alu_c = sum[SIZE];
        alu_v = (a[SIZE-1] == bx[SIZE-1]) && (sum[SIZE-1] != a[SIZE-1]);
      end
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_NOR:  alu_f = ~(a | b);
      OP_SLL: begin alu_f = sll_t[SIZE-1:0]; alu_c = sll_t[SIZE]; end
      OP_SRL: begin alu_f = srl_t[SIZE:1];   alu_c = srl_t[0];    end
      OP_SRA: begin alu_f = sra_t[SIZE:1];   alu_c = sra_t[0];    end
      OP_SLT:  alu_f = {{(SIZE-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: alu_f = {{(SIZE-1){1'b0}}, (a < b)};
      OP_MOVB: alu_f = b;
      default: alu_f = '0;
    endcase
  end

  assign f_d = Write_Select ? Input_Data : alu_f;

  // Hold stage: loads on accept, frozen under backpressure
  always_ff @(posedge Clk) begin
    if (Clr) begin
      vld_p1   <= 1'b0;
      f_p1     <= '0;
      n_p1     <= 1'b0;
      z_p1     <= 1'b0;
      c_p1     <= 1'b0;
      v_p1     <= 1'b0;
      waddr_p1 <= '0;
      wreg_p1  <= 1'b0;
      setf_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      f_p1     <= f_d;
      n_p1     <= f_d[SIZE-1];
      z_p1     <= (f_d == '0);
      c_p1     <= Write_Select ? 1'b0 : alu_c;
      v_p1     <= Write_Select ? 1'b0 : alu_v;
      waddr_p1 <= W_Addr;
      wreg_p1  <= Write_Reg;
      setf_p1  <= Set_Flags && !Write_Select;
    end else if (retire) begin
      vld_p1   <= 1'b0;
    end
  end

  // Retire: architectural register and flag update
  always_ff @(posedge Clk) begin
    if (Clr) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (retire && wreg_p1 && !is_zero_reg(waddr_p1)) begin
      rf_q[waddr_p1] <= f_p1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else if (retire && setf_p1) begin
      flag_n_q <= n_p1;
      flag_z_q <= z_p1;
      flag_c_q <= c_p1;
      flag_v_q <= v_p1;
    end
  end

  assign Out_Valid = vld_p1;
  assign F         = f_p1;
  assign N         = n_p1;
  assign Z         = z_p1;
  assign C         = c_p1;
  assign V         = v_p1;
  assign Flag_N    = flag_n_q;
  assign Flag_Z    = flag_z_q;
  assign Flag_C    = flag_c_q;
  assign Flag_V    = flag_v_q;

endmodule
